fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core: PC register, next-PC selection and IF/ID pipeline register.
- Sits downstream of the immediate extender: consumes its sign-extended 32-bit output as the branch offset.
- Drives the instruction-memory address.
- Presents the fetched instruction and its PC to decode, where the immediate field is extracted and extended.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the pipelined MIPS core.
//
// Holds the fetch PC, selects the next PC and owns the IF/ID pipeline register.
// The instruction memory is read combinationally at imem_addr (= current PC),
// so a fetched word lands in instr_d one clock after its address is driven.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   stall      : decode hazard stall; freezes PC and IF/ID, ignores redirects
//   npc_sel    : next-PC source for the instruction in D
//                (00 seq, 01 branch, 10 jump, 11 register jump)
//   br_taken   : branch condition, used only when npc_sel = 01
//   ext_imm    : sign-extended branch offset (in words)
//   j_index    : instr_index field of the jump in D
//   jr_target  : register operand for jr/jalr
//   imem_addr  : instruction-memory address (current fetch PC)
//   imem_rdata : instruction word at imem_addr
//   instr_d    : IF/ID instruction
//   pc_d       : IF/ID PC of instr_d
//   pc8_d      : pc_d + 8, the link address for jal/jalr
//
// Build option:
//   FETCH_DELAY_SLOT_EN defined   : the slot instruction after a control
//                                   transfer enters IF/ID and executes.
//   FETCH_DELAY_SLOT_EN undefined : the slot instruction is squashed to
//                                   NOP_WORD on a redirect.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] ext_imm,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d
);

  logic [31:0] pc_f_r;
  logic [31:0] instr_d_r;
  logic [31:0] pc_d_r;
  logic [31:0] pc8_d_r;

  logic [31:0] npc_s;
  logic        redirect_s;
  logic [31:0] seq_pc_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic [31:0] jr_target_s;

  assign seq_pc_s    = pc_f_r + 32'd4;
  // Branch targets are relative to the branch itself (in D), not to pc_f.
  assign br_target_s = pc_d_r + 32'd4 + (ext_imm << 2);
  assign j_target_s  = {pc_d_r[31:28], j_index, 2'b00};
  // Register targets are forced word-aligned.
  assign jr_target_s = jr_target & 32'hFFFF_FFFC;

  // Next-PC selection and redirect detection.
  always_comb begin
    npc_s      = seq_pc_s;
    redirect_s = 1'b0;
    case (npc_sel)
      2'b00: begin
        npc_s      = seq_pc_s;
        redirect_s = 1'b0;
      end
      2'b01: begin
        if (br_taken) begin
          npc_s      = br_target_s;
          redirect_s = 1'b1;
        end else begin
          npc_s      = seq_pc_s;
          redirect_s = 1'b0;
        end
      end
      2'b10: begin
        npc_s      = j_target_s;
        redirect_s = 1'b1;
      end
      2'b11: begin
        npc_s      = jr_target_s;
        redirect_s = 1'b1;
      end
      default: begin
        npc_s      = seq_pc_s;
        redirect_s = 1'b0;
      end
    endcase
  end

  // PC and IF/ID registers; a stall holds everything and masks any redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_r    <= RESET_PC;
      instr_d_r <= NOP_WORD;
      pc_d_r    <= RESET_PC;
      pc8_d_r   <= RESET_PC + 32'd8;
    end else if (!stall) begin
      pc_f_r  <= npc_s;
      pc_d_r  <= pc_f_r;
      pc8_d_r <= pc_f_r + 32'd8;
`ifdef FETCH_DELAY_SLOT_EN
      instr_d_r <= imem_rdata;
`else
      if (redirect_s) begin
        instr_d_r <= NOP_WORD;
      end else begin
        instr_d_r <= imem_rdata;
      end
`endif
    end else begin
      pc_f_r    <= pc_f_r;
      instr_d_r <= instr_d_r;
      pc_d_r    <= pc_d_r;
      pc8_d_r   <= pc8_d_r;
    end
  end

  assign imem_addr = pc_f_r;
  assign instr_d   = instr_d_r;
  assign pc_d      = pc_d_r;
  assign pc8_d     = pc8_d_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A table of stimulus rows carries absolute expected PC values; each applied
// row pushes its expectation into a queue that is popped after the clock edge.
// Hand-written sequences cover mid-run asynchronous reset and address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] ext_imm;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [31:0] jr;
    logic [31:0] e_pcf;
    logic [31:0] e_pcd;
    logic [31:0] e_word;
    logic        redir;
  } vec_t;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[20];

  localparam logic [31:0] SLOT_ADDR = 32'h0000_3010;
  localparam logic [31:0] SLOT_WORD = 32'h2408_0001;

  // Instruction memory model: address-derived words, one known slot word.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == SLOT_ADDR) return SLOT_WORD;
    else return ~a;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .ext_imm   (ext_imm),
    .j_index   (j_index),
    .jr_target (jr_target),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic br,
                              input logic [31:0] imm, input logic [25:0] jidx,
                              input logic [31:0] jr, input logic [31:0] pcf,
                              input logic [31:0] pcd, input logic [31:0] word,
                              input logic redir);
    vec_t v;
    v.stall = st; v.sel = sel; v.br = br; v.imm = imm; v.jidx = jidx; v.jr = jr;
    v.e_pcf = pcf; v.e_pcd = pcd; v.e_word = word; v.redir = redir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Expected IF/ID instruction: slot word survives only with delay slots on.
  function automatic logic [31:0] exp_instr(input logic [31:0] word, input logic redir);
`ifdef FETCH_DELAY_SLOT_EN
    return word;
`else
    return redir ? 32'h0000_0000 : word;
`endif
  endfunction

  // Drive one row (called just after a falling edge), check after next rise.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    stall     = v.stall;
    npc_sel   = v.sel;
    br_taken  = v.br;
    ext_imm   = v.imm;
    j_index   = v.jidx;
    jr_target = v.jr;
    e.pcf   = v.e_pcf;
    e.pcd   = v.e_pcd;
    e.instr = exp_instr(v.e_word, v.redir);
    e.pc8   = v.e_pcd + 32'd8;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk($sformatf("row%0d_imem_addr", idx), imem_addr, got.pcf);
    chk($sformatf("row%0d_pc_d", idx), pc_d, got.pcd);
    chk($sformatf("row%0d_instr_d", idx), instr_d, got.instr);
    chk($sformatf("row%0d_pc8_d", idx), pc8_d, got.pc8);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0000_3000);
    chk({tag, "_pc_d"}, pc_d, 32'h0000_3000);
    chk({tag, "_instr_d"}, instr_d, 32'h0000_0000);
    chk({tag, "_pc8_d"}, pc8_d, 32'h0000_3008);
  endtask

  initial begin
    //          st  sel   br    imm            jidx        jr             pc_f           pc_d           word                      redir
    vecs[0]  = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3004, 32'h0000_3000, imem_word(32'h0000_3000), 0);
    vecs[1]  = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3008, 32'h0000_3004, imem_word(32'h0000_3004), 0);
    vecs[2]  = mk(1, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3008, 32'h0000_3004, imem_word(32'h0000_3004), 0);
    vecs[3]  = mk(1, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3008, 32'h0000_3004, imem_word(32'h0000_3004), 0);
    vecs[4]  = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_300C, 32'h0000_3008, imem_word(32'h0000_3008), 0);
    vecs[5]  = mk(0, 2'b01, 0, 32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_3010, 32'h0000_300C, imem_word(32'h0000_300C), 0);
    vecs[6]  = mk(1, 2'b01, 1, 32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_3010, 32'h0000_300C, imem_word(32'h0000_300C), 0);
    vecs[7]  = mk(0, 2'b01, 1, 32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_3008, 32'h0000_3010, SLOT_WORD,                1);
    vecs[8]  = mk(0, 2'b11, 0, 32'h0,         26'h0,      32'h0000_3007, 32'h0000_3004, 32'h0000_3008, imem_word(32'h0000_3008), 1);
    vecs[9]  = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3008, 32'h0000_3004, imem_word(32'h0000_3004), 0);
    vecs[10] = mk(0, 2'b01, 1, 32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_3000, 32'h0000_3008, imem_word(32'h0000_3008), 1);
    vecs[11] = mk(0, 2'b01, 0, 32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_3004, 32'h0000_3000, imem_word(32'h0000_3000), 0);
    vecs[12] = mk(0, 2'b11, 0, 32'h0,         26'h0,      32'h0000_3023, 32'h0000_3020, 32'h0000_3004, imem_word(32'h0000_3004), 1);
    vecs[13] = mk(0, 2'b11, 0, 32'h0,         26'h0,      32'h0000_3010, 32'h0000_3010, 32'h0000_3020, imem_word(32'h0000_3020), 1);
    vecs[14] = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3014, 32'h0000_3010, SLOT_WORD,                0);
    vecs[15] = mk(0, 2'b10, 0, 32'h0,         26'h0000C10, 32'h0,        32'h0000_3040, 32'h0000_3014, imem_word(32'h0000_3014), 1);
    vecs[16] = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3044, 32'h0000_3040, imem_word(32'h0000_3040), 0);
    vecs[17] = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3048, 32'h0000_3044, imem_word(32'h0000_3044), 0);
    vecs[18] = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_304C, 32'h0000_3048, imem_word(32'h0000_3048), 0);
    vecs[19] = mk(0, 2'b00, 0, 32'h0,         26'h0,      32'h0,         32'h0000_3050, 32'h0000_304C, imem_word(32'h0000_304C), 0);

    rst_n = 1'b0; stall = 1'b0; npc_sel = 2'b00; br_taken = 1'b0;
    ext_imm = 32'h0; j_index = 26'h0; jr_target = 32'h0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(vecs[i], i);

    // Asynchronous reset between edges at pc_f = 0x3050.
    stall = 1'b1;
    @(posedge clk);
    #3;
    chk("pre_async_imem_addr", imem_addr, 32'h0000_3050);
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart, then jump to the top of the address space and wrap to 0.
    apply(mk(0, 2'b00, 0, 32'h0, 26'h0, 32'h0,
             32'h0000_3004, 32'h0000_3000, imem_word(32'h0000_3000), 0), 100);
    apply(mk(0, 2'b11, 0, 32'h0, 26'h0, 32'hFFFF_FFFF,
             32'hFFFF_FFFC, 32'h0000_3004, imem_word(32'h0000_3004), 1), 101);
    apply(mk(0, 2'b00, 0, 32'h0, 26'h0, 32'h0,
             32'h0000_0000, 32'hFFFF_FFFC, imem_word(32'hFFFF_FFFC), 0), 102);
    // Positive branch offset from pc_d = 0xFFFF_FFFC wraps as well.
    apply(mk(0, 2'b01, 1, 32'h0000_0010, 26'h0, 32'h0,
             32'h0000_0040, 32'h0000_0000, imem_word(32'h0000_0000), 1), 103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
